dmem_lsu: RTL
=============

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DEPTH, default 128: data-memory depth in 32-bit words; all addresses are taken modulo DEPTH*4.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1: access request present.
REQ-005 SHALL have port req_ready, output, 1: block accepts a request this cycle.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 SHALL have port req_signed, input, 1: sign-extend sub-word loads.
REQ-009 SHALL have port req_addr, input, 32: byte address.
REQ-010 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1: response present.
REQ-012 SHALL have port resp_ready, input, 1: consumer takes the response.
REQ-013 SHALL have port resp_rdata, output, 32: load result; 0 for stores.
REQ-014 SHALL have port resp_err, output, 1: request rejected.
REQ-015 SHALL have port mem_we, output, 1: data-memory write enable.
REQ-016 SHALL have port mem_adr, output, 32: data-memory byte address; memory indexes the word at adr/4.
REQ-017 SHALL have port mem_din, output, 32: data-memory write word.
REQ-018 SHALL have port mem_dout, input, 32: data-memory combinational read word at mem_adr.

Function
REQ-019 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-020 SHALL accept a request on a rising edge with req_valid & req_ready, latching we, size, signed, addr and wdata.
REQ-021 SHALL, from IDLE on accept: word store -> WRITE; sub-word store -> READ; load -> READ; illegal size -> RESP with resp_err = 1.
REQ-022 SHALL drive mem_adr = {latched addr[31:2], 2'b00} throughout READ and WRITE.
REQ-023 SHALL, in READ, capture mem_dout at the cycle end; load -> RESP; sub-word store -> WRITE.
REQ-024 SHALL assert mem_we for exactly one cycle (WRITE), then -> RESP; mem_we = 0 in all other states.
REQ-025 SHALL, for a word store, set mem_din = wdata; for half/byte, mem_din = captured word with only lane addr[1] (half) or addr[1:0] (byte) replaced by wdata[15:0] / wdata[7:0]; little-endian lanes.
REQ-026 SHALL, for loads, set resp_rdata = selected lane, zero-extended if req_signed = 0, sign-extended from bit 7/15 if 1.
REQ-027 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready = 1, then -> IDLE on that edge.
REQ-028 SHALL yield latency from accept to resp_valid: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, error 1 cycle.
REQ-029 SHALL ignore req_valid outside IDLE; a back-to-back request is accepted on the cycle after a RESP handshake, not in the same cycle.

Reset
REQ-030 SHALL, on rst_n = 0 in any state, immediately force IDLE, req_ready = 1 (after release), resp_valid = 0, resp_rdata = 0, resp_err = 0, mem_we = 0, mem_adr = 0, mem_din = 0.
REQ-031 SHALL abandon an in-flight access on reset with no memory write issued after reset assertion.

Configuration
REQ-032 SHALL honour macro DMEM_LSU_ALIGN_CHECK_EN: when defined, a half access with addr[0] = 1 or a word access with addr[1:0] != 0 goes IDLE -> RESP with resp_err = 1, resp_rdata = 0 and no memory access.
REQ-033 SHALL, when DMEM_LSU_ALIGN_CHECK_EN is undefined, ignore addr[0] for halves and addr[1:0] for words; resp_err is then set only for size 11.

Verification
REQ-034 SHALL test: word store addr 0x10, data 0xDEADBEEF -> mem_we one cycle with mem_adr 0x10, mem_din 0xDEADBEEF; resp_valid 2 cycles after accept.
REQ-035 SHALL test: word at 0x10 = 0xDEADBEEF, byte store addr 0x12 data 0x55 -> mem_din 0xDE55BEEF, 3-cycle latency.
REQ-036 SHALL test: word 0x0000_80F0 at 0x20; signed half load 0x20 -> 0xFFFF80F0; unsigned byte load 0x21 -> 0x00000080.
REQ-037 SHALL test: with DMEM_LSU_ALIGN_CHECK_EN, word load addr 0x22 -> resp_err = 1, resp_rdata = 0, mem_we never asserted, 1-cycle latency.
REQ-038 SHALL test: rst_n low during WRITE -> mem_we drops immediately, state IDLE, target word unchanged.
REQ-039 SHALL test: resp_ready held low 5 cycles -> resp_valid/resp_rdata stable, req_ready = 0 throughout.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between a request/response port and a single-ported
// data memory with a combinational read. Sub-word stores use read-modify-write.
//   clk, rst_n                : clock, asynchronous active-low reset
//   req_valid/req_ready       : request handshake (ready only in IDLE)
//   req_we/size/signed        : store/load, 00 byte 01 half 10 word 11 illegal, sign-extend
//   req_addr/req_wdata        : byte address, right-aligned store data
//   resp_valid/resp_ready     : response handshake
//   resp_rdata/resp_err       : load result (0 for stores), rejected request
//   mem_we/mem_adr/mem_din    : memory write enable, word-aligned byte address, write word
//   mem_dout                  : memory read word at mem_adr
// Macro DMEM_LSU_ALIGN_CHECK_EN: reject misaligned half/word accesses with resp_err.
module dmem_lsu #(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [31:0] AMOD = 32'(DEPTH * 4);

    state_t      r_state, w_next;
    logic        r_we, r_signed, r_err;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_word, r_rdata;
    logic        w_accept, w_bad;
    logic [4:0]  w_sh;
    logic [31:0] w_lane, w_load, w_mask, w_rep, w_merge, w_adr;

    assign w_accept = req_valid && (r_state == IDLE);

`ifdef DMEM_LSU_ALIGN_CHECK_EN
    assign w_bad = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign w_bad = (req_size == 2'b11);
`endif

    // Lane shift: words always use lane 0, so unaligned low bits are ignored.
    assign w_sh    = (r_size == 2'b00) ? {r_addr[1:0], 3'b000} :
                     (r_size == 2'b01) ? {r_addr[1], 4'b0000} : 5'd0;
    assign w_lane  = mem_dout >> w_sh;
    assign w_load  = (r_size == 2'b00) ? {{24{r_signed & w_lane[7]}}, w_lane[7:0]} :
                     (r_size == 2'b01) ? {{16{r_signed & w_lane[15]}}, w_lane[15:0]} : w_lane;
    assign w_mask  = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
    assign w_rep   = (r_size == 2'b00) ? {4{r_wdata[7:0]}} : {2{r_wdata[15:0]}};
    assign w_merge = (r_size == 2'b10) ? r_wdata : ((r_word & ~w_mask) | (w_rep & w_mask));
    assign w_adr   = {r_addr[31:2], 2'b00} % AMOD;

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_we     = (r_state == WRITE);
    assign mem_adr    = (r_state == READ || r_state == WRITE) ? w_adr : 32'd0;
    assign mem_din    = (r_state == WRITE) ? w_merge : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = w_bad ? RESP : (req_we && req_size == 2'b10) ? WRITE : READ;
            READ:    w_next = r_we ? WRITE : RESP;
            WRITE:   w_next = RESP;
            RESP:    if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_size   <= 2'b00;
            r_signed <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_word   <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_size   <= req_size;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_err    <= w_bad;
                r_rdata  <= 32'd0;
            end
            if (r_state == READ) begin
                r_word <= mem_dout;
                if (!r_we) r_rdata <= w_load;
            end
        end
    end
endmodule
